// File: rtl/sng_pkg.sv
// sng_pkg: shared types and constants for the stochastic stream scheduler
package sng_pkg;
   localparam int BIN_LEN = 6;
   localparam int STREAM_LEN_DEFAULT = 63;
   localparam logic [BIN_LEN-1:0] LFSR_LOCKUP = 6'h3F;
   typedef enum logic [1:0] {IDLE, SEED, STREAM, DONE} sched_state_t;
endpackage

// File: rtl/sng_stream_scheduler_lfsr.sv
// sng_stream_scheduler_lfsr: 6-bit XNOR LFSR (taps 6,5) with synchronous load
module sng_stream_scheduler_lfsr
   import sng_pkg::*;
(
   input  logic               clock,
   input  logic               reset_n,
   input  logic               enable,
   input  logic               init,
   input  logic [BIN_LEN-1:0] init_val,
   output logic [BIN_LEN-1:0] lfsr_out
);
   // load the seed on init, otherwise shift in the XNOR of the two top bits
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) lfsr_out <= '0;
      else if (enable) lfsr_out <= init ? init_val : {lfsr_out[BIN_LEN-2:0], lfsr_out[BIN_LEN-1] ~^ lfsr_out[BIN_LEN-2]};
endmodule

// File: rtl/sng_stream_scheduler.sv
// sng_stream_scheduler: round-robin sharing of one LFSR among stochastic number generator clients
module sng_stream_scheduler
   import sng_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int STREAM_LEN = STREAM_LEN_DEFAULT,
   parameter int ID_W       = $clog2(NUM_REQ)
) (
   input  logic                            clock,
   input  logic                            reset_n,
   input  logic [NUM_REQ-1:0]              req,
   input  logic [NUM_REQ-1:0][BIN_LEN-1:0] req_value,
   input  logic [NUM_REQ-1:0][BIN_LEN-1:0] req_seed,
   output logic [ID_W-1:0]                 grant_id,
   output logic                            busy,
   output logic                            bit_valid,
   output logic                            bit_out,
   input  logic                            bit_ready,
   output logic                            done
);
   sched_state_t       state, state_nx;
   logic [ID_W-1:0]    last_id, pick;
   logic [BIN_LEN-1:0] value, seed, lfsr_out;
   logic [7:0]         beat_cnt;
   logic               lfsr_en, lfsr_init, last_beat;

   // nearest requester above 'from', wrapping; scanned far-to-near so the nearest wins
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [ID_W-1:0] from);
      int k;
      rr_pick = from;
      for (int i = NUM_REQ; i >= 1; i--) begin
         k = (int'(from) + i) % NUM_REQ;
         if (((r >> k) & NUM_REQ'(1)) != '0) rr_pick = ID_W'(k);
      end
   endfunction

   assign pick      = rr_pick(req, last_id);
   assign last_beat = beat_cnt == 8'(STREAM_LEN - 1);
   assign busy      = state != IDLE;
   assign bit_valid = state == STREAM;
   assign done      = state == DONE;
   assign bit_out   = bit_valid && (lfsr_out < value);

   // state register
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_nx;

   // next state and LFSR control: seed once, then shift only on accepted beats
   always_comb begin
      state_nx  = state;
      lfsr_en   = 1'b0;
      lfsr_init = 1'b0;
      unique case (state)
         IDLE:   if (|req) state_nx = SEED;
         SEED:   begin
            state_nx  = STREAM;
            lfsr_en   = 1'b1;
            lfsr_init = 1'b1;
         end
         STREAM: begin
            lfsr_en = bit_ready;
            if (bit_ready && last_beat) state_nx = DONE;
         end
         DONE:   state_nx = IDLE;
      endcase
   end

   // job latch on grant (frozen for the whole job) and accepted-beat counter
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         grant_id <= '0;
         last_id  <= ID_W'(NUM_REQ - 1);
         value    <= '0;
         seed     <= '0;
         beat_cnt <= '0;
      end else begin
         if (state == IDLE && |req) begin
            grant_id <= pick;
            last_id  <= pick;
            value    <= req_value[pick];
            seed     <= req_seed[pick];
         end
         if (state == STREAM && bit_ready) beat_cnt <= last_beat ? '0 : beat_cnt + 8'd1;
      end

   sng_stream_scheduler_lfsr u_lfsr (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable   (lfsr_en),
      .init     (lfsr_init),
      .init_val (seed == LFSR_LOCKUP ? '0 : seed),
      .lfsr_out (lfsr_out)
   );
endmodule

// File: tb/tb_sng_stream_scheduler.sv
// tb_sng_stream_scheduler: randomized scoreboard bench for the stochastic stream scheduler
module tb_sng_stream_scheduler;
   localparam int N = 4;
   localparam int L = 63;

   typedef struct {
      int id;
      int ones;
      int t0;
   } exp_t;

   logic                clock = 1'b0;
   logic                reset_n;
   logic [N-1:0]        req;
   logic [N-1:0][5:0]   req_value, req_seed;
   logic [1:0]          grant_id;
   logic                busy, bit_valid, bit_out, bit_ready, done;

   exp_t exp_q[$];
   int   npass = 0, ntot = 0;
   int   cyc = 0;
   int   model_last = N - 1;
   bit   stall_mode = 1'b0;
   int   ones, beats, first_cyc;
   bit   prev_stall, prev_bit;

   sng_stream_scheduler #(.NUM_REQ(N), .STREAM_LEN(L)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req       (req),
      .req_value (req_value),
      .req_seed  (req_seed),
      .grant_id  (grant_id),
      .busy      (busy),
      .bit_valid (bit_valid),
      .bit_out   (bit_out),
      .bit_ready (bit_ready),
      .done      (done)
   );

   initial forever #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      bit_ready = 1'b1;
      forever begin
         @(posedge clock);
         #1;
         bit_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      ntot++;
      if (act == exp) npass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   // the LFSR covers 0..L-1 once per job, so the ones count is how many of those lie below v
   function automatic int ones_of(input logic [5:0] v);
      int n = 0;
      for (int s = 0; s < L; s++) if (s < int'(v)) n++;
      return n;
   endfunction

   // round-robin reference: requester at the smallest forward distance after 'last'
   function automatic int next_client(input logic [N-1:0] m, input int last);
      int best = -1, bestd = N;
      for (int id = 0; id < N; id++)
         if (m[id] && ((id - last - 1 + 2 * N) % N) < bestd) begin
            bestd = (id - last - 1 + 2 * N) % N;
            best  = id;
         end
      return best;
   endfunction

   // monitor: accumulates accepted beats and pops the scoreboard on each done
   always @(negedge clock) begin
      if (!reset_n) begin
         ones = 0; beats = 0; first_cyc = -1; prev_stall = 0; prev_bit = 0;
      end else begin
         exp_t e;
         if (prev_stall) check("stall_hold", int'(bit_out), int'(prev_bit));
         if (bit_valid && first_cyc < 0) first_cyc = cyc;
         if (bit_valid && bit_ready) begin
            ones += int'(bit_out);
            beats++;
         end
         prev_stall = bit_valid && !bit_ready;
         prev_bit   = bit_out;
         if (done) begin
            check("done_no_valid", int'(bit_valid), 0);
            check("scoreboard_nonempty", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("grant_id", int'(grant_id), e.id);
               check("ones_count", ones, e.ones);
               check("beat_count", beats, L);
               if (e.t0 >= 0) begin
                  check("first_valid_cycle", first_cyc, e.t0 + 2);
                  check("done_cycle", cyc, e.t0 + 2 + L);
               end
            end
            ones = 0; beats = 0; first_cyc = -1;
         end
      end
   end

   task automatic run_jobs(input logic [N-1:0] mask, input int njobs, input bit rep, input bit timed, input bit stall);
      int order[$];
      logic [N-1:0] m = mask;
      int k = 0, budget = 0;
      exp_t e;
      @(negedge clock);
      stall_mode = stall;
      for (int j = 0; j < njobs; j++) begin
         e.id   = next_client(m, model_last);
         e.ones = ones_of(req_value[e.id]);
         e.t0   = (timed && j == 0) ? cyc : -1;
         exp_q.push_back(e);
         order.push_back(e.id);
         model_last = e.id;
         if (!rep) m[e.id] = 1'b0;
      end
      req = mask;
      while (k < njobs && budget < 300 * njobs) begin
         @(negedge clock);
         budget++;
         if (done) begin
            if (!rep) req[order[k]] = 1'b0;
            k++;
         end
      end
      req = '0;
      stall_mode = 1'b0;
      check("jobs_completed", k, njobs);
   endtask

   task automatic check_reset_outputs();
      check("rst_busy", int'(busy), 0);
      check("rst_bit_valid", int'(bit_valid), 0);
      check("rst_bit_out", int'(bit_out), 0);
      check("rst_done", int'(done), 0);
      check("rst_grant_id", int'(grant_id), 0);
   endtask

   initial begin
      int b, r;
      exp_t e;
      reset_n = 1'b0; req = '0; req_value = '0; req_seed = '0;
      repeat (2) @(negedge clock);
      check_reset_outputs();
      reset_n = 1'b1;

      req_value[0] = 6'd32; req_seed[0] = 6'h01;
      run_jobs(4'b0001, 1, 0, 1, 0);
      req_value[0] = 6'd0; req_seed[0] = 6'($urandom);
      run_jobs(4'b0001, 1, 0, 0, 0);
      req_value[0] = 6'd63; req_seed[0] = 6'($urandom);
      run_jobs(4'b0001, 1, 0, 0, 0);
      req_value[0] = 6'd32; req_seed[0] = 6'h3F;
      run_jobs(4'b0001, 1, 0, 0, 0);

      for (int i = 0; i < N; i++) begin
         req_value[i] = 6'($urandom); req_seed[i] = 6'($urandom);
      end
      run_jobs(4'b1000, 1, 0, 0, 0);
      run_jobs(4'b1111, 5, 1, 0, 0);
      run_jobs(4'b1111, 4, 0, 0, 1);

      r = int'($urandom_range(1, 62));
      @(negedge clock);
      req_value[2] = 6'(r); req_seed[2] = 6'($urandom);
      e.id = 2; e.ones = ones_of(6'(r)); e.t0 = -1;
      exp_q.push_back(e);
      model_last = 2;
      req = 4'b0100;
      b = 0;
      while (beats < 10 && b < 200) begin @(negedge clock); b++; end
      req = '0; req_value[2] = ~6'(r);
      b = 0;
      while (!done && b < 200) begin @(negedge clock); b++; end
      check("drop_job_done", int'(done), 1);

      @(negedge clock);
      req_value[0] = 6'($urandom); req_seed[0] = 6'($urandom);
      e.id = 0; e.ones = ones_of(req_value[0]); e.t0 = -1;
      exp_q.push_back(e);
      req = 4'b0001;
      b = 0;
      while (beats < 20 && b < 200) begin @(negedge clock); b++; end
      check("reached_beat20", int'(beats >= 20), 1);
      #2 reset_n = 1'b0;
      #1 check_reset_outputs();
      exp_q.delete();
      req = '0;
      model_last = N - 1;
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      req_value[1] = 6'($urandom); req_seed[1] = 6'($urandom);
      run_jobs(4'b0010, 1, 0, 1, 0);

      for (int it = 0; it < 6; it++) begin
         logic [N-1:0] m;
         for (int i = 0; i < N; i++) begin
            req_value[i] = 6'($urandom); req_seed[i] = 6'($urandom);
         end
         m = N'($urandom_range(1, 15));
         run_jobs(m, $countones(m), 0, 0, 1'($urandom_range(0, 1)));
      end

      repeat (3) @(negedge clock);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule

// File: doc/sng_stream_scheduler.md
# sng_stream_scheduler

Shares one 6-bit XNOR LFSR random source among `NUM_REQ` stochastic-number-generator clients. Arbitrates round-robin, seeds the LFSR per job, and emits a `STREAM_LEN`-bit unipolar stochastic bitstream for the granted client's binary value, with valid/ready backpressure. Sits between the binary operand front-end and the stochastic compute array. It replaces per-lane LFSR instances where area matters.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesting clients, 2..16.
- `STREAM_LEN`, default 63: bits per job, equal to 2^`BIN_LEN`-1 (`BIN_LEN` = 6 from `sys_defs.svh`), range 1..255.
- `ID_W`, default $clog2(`NUM_REQ`): client index width.

Ports:
- `clock`  in  1: the single clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  `NUM_REQ`: per-client job request, level, held until that client's `done`.
- `req_value`  in  `NUM_REQ`×`BIN_LEN`: per-client binary magnitude.
- `req_seed`  in  `NUM_REQ`×`BIN_LEN`: per-client LFSR seed.
- `grant_id`  out  `ID_W`: client owning the stream; valid while `busy`.
- `busy`  out  1: a job is in SEED, STREAM or DONE.
- `bit_valid`  out  1: `bit_out` is valid.
- `bit_out`  out  1: stochastic bit.
- `bit_ready`  in  1: consumer accepts the bit.
- `done`  out  1: one-cycle pulse that ends a job, qualified by `grant_id`.

## Operation
- The FSM has four states: IDLE, SEED, STREAM and DONE.
- **IDLE**
  - If any `req` bit is set, pick the first set bit after `last_id`, searching upward with wrap.
  - Latch `grant_id`, value and seed; update `last_id`; go to SEED.
  - `last_id` resets to `NUM_REQ`-1, so client 0 wins first.
- **SEED** (one cycle)
  - Drive LFSR `enable`=1 and `init`=1 with the latched seed; go to STREAM.
  - A seed of 6'h3F is the lockup state for XNOR feedback, so it is replaced by 6'h00.
- **STREAM**
  - `bit_valid`=1 and `bit_out` = (`lfsr_out` < `value`), an unsigned `BIN_LEN`-bit compare.
  - On `bit_valid`&&`bit_ready`: pulse LFSR `enable` (shift) and increment `beat_cnt` (8-bit).
  - While `bit_ready`=0, both `bit_out` and the LFSR hold.
  - On the accepted beat where `beat_cnt` = `STREAM_LEN`-1, go to DONE and clear `beat_cnt`.
- **DONE** (one cycle)
  - `done`=1 and `bit_valid`=0; go to IDLE.
- Latched `value`, seed and `grant_id` are frozen for the whole job. Changes on `req_*` or deassertion of `req` mid-job are ignored, and the job always completes.
- With `STREAM_LEN`=63 and the taps at bits 6 and 5 (XNOR), the LFSR visits 0..62 exactly once. The ones count therefore equals `value` exactly, for value 0..63.
- A request made while the block is busy waits. It is arbitrated in the first IDLE cycle.

## Timing
- Reset values: `busy`=0, `bit_valid`=0, `bit_out`=0, `done`=0, `grant_id`=0, state IDLE, `beat_cnt`=0.
- Reset taken mid-job aborts the job immediately. No `done` is issued, and the LFSR contents are don't-care because the next job reseeds.
- Per-job cycle timeline, with T = the cycle a `req` is first seen in IDLE:
  - T: grant.
  - T+1: SEED.
  - T+2: first `bit_valid`.
  - T+2+`STREAM_LEN`-1: last beat, with `bit_ready` held high.
  - T+2+`STREAM_LEN`: `done`.
  - T+3+`STREAM_LEN`: earliest next grant.
- Job length is `STREAM_LEN`+3 cycles when there is no backpressure.
- `busy` is high from T+1 through the DONE cycle inclusive.
- `bit_out` is a function of registered state only; there is no combinational path from `bit_ready`.
- Outputs are registered or decoded from state; `req` has no combinational path to outputs.

## Structure
- Shared package `sng_pkg`:
  - state enum `sched_state_t` {IDLE, SEED, STREAM, DONE};
  - `LFSR_LOCKUP` = 6'h3F;
  - the `STREAM_LEN` default.
- One sub-module: the existing `LFSR`, instantiated once and driven by `enable`/`init`/`init_val` from the FSM.
- Round-robin pick is an internal function; it needs no separate module.

## Test plan
- Single client 0, value 32, seed 6'h01, `bit_ready`=1:
  - exactly 63 beats, 32 ones;
  - first `bit_valid` at T+2, `done` at T+65, `grant_id`=0.
- Value 0 gives 0 ones; value 63 gives 63 ones; seed 6'h3F with value 32 gives 32 ones and the LFSR never sticks at 6'h3F.
- All four `req` high, repeating: grant order 0,1,2,3,0; each job receives its own value's ones count.
- `bit_ready` toggling 1,0,0,1 pseudo-randomly: the ones count is unchanged, `bit_out` is stable while stalled, and `done` only follows the 63rd accepted beat.
- Client 2 drops `req` and changes `req_value` mid-stream: the job completes with the original count and `done` is issued with `grant_id`=2.
- `reset_n` asserted at beat 20: all outputs drop to their reset values asynchronously. After release with client 1 requesting, client 0 ordering restarts and a full 63-beat job runs.
